// File: rtl/barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Carry output is added when BARREL_SHIFTER_PIPE_CARRY_EN is defined.
package barrel_pkg;

    typedef enum logic [1:0] {
        BS_LSL_LSR = 2'b00,
        BS_ROT     = 2'b01,
        BS_ASH     = 2'b10,
        BS_RSVD    = 2'b11
    } bs_op_e;

    localparam logic BS_DIR_RIGHT = 1'b0;
    localparam logic BS_DIR_LEFT  = 1'b1;

    // Widest word bit_rev can handle; callers zero-extend and realign.
    localparam int BS_MAX_W = 1024;

    function automatic logic [BS_MAX_W-1:0] bit_rev(input logic [BS_MAX_W-1:0] d);
        logic [BS_MAX_W-1:0] r;
        for (int i = 0; i < BS_MAX_W; i++) begin
            r[i] = d[BS_MAX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One combinational step of the shifter: right shift / rotate / sign-fill by SHIFT.
// Carry ports exist only when BARREL_SHIFTER_PIPE_CARRY_EN is defined.
module barrel_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic             en,
    input  logic             rot,
    input  logic             sgn,
    input  logic [WIDTH-1:0] data_in,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    input  logic             carry_in,
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] wrapped;
    logic [WIDTH-1:0] sign_fill;

    assign shifted   = data_in >> SHIFT;
    assign wrapped   = data_in << (WIDTH - SHIFT);
    assign sign_fill = {WIDTH{data_in[WIDTH-1]}} << (WIDTH - SHIFT);

    always_comb begin
        data_out = data_in;
        if (en) begin
            if (rot) begin
                data_out = shifted | wrapped;
            end else if (sgn) begin
                data_out = shifted | sign_fill;
            end else begin
                data_out = shifted;
            end
        end
    end

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    // The last enabled stage sees the bit that ends up being the final one shifted out.
    assign carry_out = en ? data_in[SHIFT-1] : carry_in;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter, one register stage per shift-amount bit, global stall.
// Optional out_carry port enabled by BARREL_SHIFTER_PIPE_CARRY_EN.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic                     in_dir,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    output logic                     out_carry,
`endif
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);

    logic             advance;
    bs_op_e           entry_op;
    logic             entry_rot;
    logic             entry_sgn;
    logic [WIDTH-1:0] entry_data;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    // Arithmetic left degenerates to logical left, so sign fill only applies going right.
    assign entry_op   = bs_op_e'(in_op);
    assign entry_rot  = (entry_op == BS_ROT);
    assign entry_sgn  = (entry_op == BS_ASH) && (in_dir == BS_DIR_RIGHT);
    assign entry_data = (in_dir == BS_DIR_LEFT)
                      ? WIDTH'(bit_rev(BS_MAX_W'(in_data)) >> (BS_MAX_W - WIDTH))
                      : in_data;

    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        logic             prev_valid;
        logic             prev_rot;
        logic             prev_sgn;
        logic             prev_dir;
        logic             prev_en;
        logic [WIDTH-1:0] prev_data;
        logic [TAG_W-1:0] prev_tag;
        logic [WIDTH-1:0] data_next;

        logic             valid_reg;
        logic             dir_reg;
        logic [WIDTH-1:0] data_reg;
        logic [TAG_W-1:0] tag_reg;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        logic             prev_carry;
        logic             carry_next;
        logic             carry_reg;
`endif

        if (gi == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_rot   = entry_rot;
            assign prev_sgn   = entry_sgn;
            assign prev_dir   = in_dir;
            assign prev_en    = in_amt[0];
            assign prev_data  = entry_data;
            assign prev_tag   = in_tag;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            assign prev_carry = 1'b0;
`endif
        end else begin : g_body
            assign prev_valid = g_stage[gi-1].valid_reg;
            assign prev_rot   = g_stage[gi-1].g_fwd.rot_reg;
            assign prev_sgn   = g_stage[gi-1].g_fwd.sgn_reg;
            assign prev_dir   = g_stage[gi-1].dir_reg;
            assign prev_en    = g_stage[gi-1].g_fwd.amt_reg[gi];
            assign prev_data  = g_stage[gi-1].data_reg;
            assign prev_tag   = g_stage[gi-1].tag_reg;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            assign prev_carry = g_stage[gi-1].carry_reg;
`endif
        end

        barrel_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << gi)
        ) u_stage (
            .en        (prev_en),
            .rot       (prev_rot),
            .sgn       (prev_sgn),
            .data_in   (prev_data),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            .carry_in  (prev_carry),
            .carry_out (carry_next),
`endif
            .data_out  (data_next)
        );

        // Payload only loads with a real beat so the output holds its last result through bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                dir_reg   <= BS_DIR_RIGHT;
                data_reg  <= '0;
                tag_reg   <= '0;
            end else if (advance) begin
                valid_reg <= prev_valid;
                if (prev_valid) begin
                    dir_reg  <= prev_dir;
                    data_reg <= data_next;
                    tag_reg  <= prev_tag;
                end
            end
        end

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        always_ff @(posedge clk) begin
            if (rst) begin
                carry_reg <= 1'b0;
            end else if (advance && prev_valid) begin
                carry_reg <= carry_next;
            end
        end
`endif

        // Control needed only by later stages; the final stage has no successor.
        if (gi < SHW - 1) begin : g_fwd
            logic [SHW-1:0] amt_src;
            logic [SHW-1:0] amt_reg;
            logic           rot_reg;
            logic           sgn_reg;

            if (gi == 0) begin : g_src_head
                assign amt_src = in_amt;
            end else begin : g_src_body
                assign amt_src = g_stage[gi-1].g_fwd.amt_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_reg <= '0;
                    rot_reg <= 1'b0;
                    sgn_reg <= 1'b0;
                end else if (advance && prev_valid) begin
                    amt_reg <= amt_src;
                    rot_reg <= prev_rot;
                    sgn_reg <= prev_sgn;
                end
            end
        end
    end

    assign out_valid = g_stage[SHW-1].valid_reg;
    assign out_tag   = g_stage[SHW-1].tag_reg;
    assign out_data  = (g_stage[SHW-1].dir_reg == BS_DIR_LEFT)
                     ? WIDTH'(bit_rev(BS_MAX_W'(g_stage[SHW-1].data_reg)) >> (BS_MAX_W - WIDTH))
                     : g_stage[SHW-1].data_reg;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    assign out_carry = g_stage[SHW-1].carry_reg;
`endif

endmodule
